// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter driving open-collector clock/data enables.
// Optional PS2_TX_RETRY_EN: resend the latched frame up to two more times before reporting an error.
module ps2_host_tx #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_US = 15_000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    input  logic       i_ps2_clk_in,
    input  logic       i_ps2_dat_in,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_dat_oe,
    output logic       o_rx_inhibit,
    output logic       o_tx_done,
    output logic       o_tx_err
);
    localparam longint INH_L   = longint'(INHIBIT_US) * longint'(CLK_HZ) / 1_000_000;
    localparam longint TO_L    = longint'(TIMEOUT_US) * longint'(CLK_HZ) / 1_000_000;
    localparam int     INH_CYC = int'(INH_L);
    localparam int     TO_CYC  = int'(TO_L);
    localparam int     MAX_CYC = (INH_CYC > TO_CYC) ? INH_CYC : TO_CYC;
    localparam int     CW      = $clog2(MAX_CYC + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INH_CYC - 2);
    localparam logic [CW-1:0] TO_LAST  = CW'(TO_CYC - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_DATA, S_ACK, S_WAIT_IDLE, S_ERR
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_clk_m, r_clk_s, r_clk_q, r_dat_m, r_dat_s;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [3:0]    r_bitcnt, w_bitcnt_nxt;
    logic [10:0]   r_shift, w_shift_nxt;
    logic          r_clk_oe, w_clk_oe_nxt;
    logic          r_dat_oe, w_dat_oe_nxt;
    logic          r_done, w_done_nxt;
    logic          w_fall, w_timeout, w_fail;
    logic [10:0]   w_frame;
`ifdef PS2_TX_RETRY_EN
    logic [10:0]   r_frame, w_frame_nxt;
    logic [1:0]    r_retry, w_retry_nxt;
`endif

    // Start bit sits in bit 0 so the request phase drives it straight from the shifter.
    assign w_frame   = {1'b1, ~^i_tx_data, i_tx_data, 1'b0};
    assign w_fall    = r_clk_q & ~r_clk_s;
    assign w_timeout = (r_cnt == TO_LAST);

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_clk_oe_nxt = r_clk_oe;
        w_dat_oe_nxt = r_dat_oe;
        w_done_nxt   = 1'b0;
        w_fail       = 1'b0;
`ifdef PS2_TX_RETRY_EN
        w_frame_nxt  = r_frame;
        w_retry_nxt  = r_retry;
`endif
        case (r_state)
            S_IDLE: if (i_tx_valid) begin
                w_state_nxt  = S_INHIBIT;
                w_cnt_nxt    = '0;
                w_bitcnt_nxt = '0;
                w_shift_nxt  = w_frame;
                w_clk_oe_nxt = 1'b1;
                w_dat_oe_nxt = 1'b0;
`ifdef PS2_TX_RETRY_EN
                w_frame_nxt  = w_frame;
                w_retry_nxt  = '0;
`endif
            end
            S_INHIBIT: begin
                w_cnt_nxt = r_cnt + ONE;
                if (r_cnt == INH_LAST) begin
                    w_dat_oe_nxt = ~r_shift[0];
                    w_state_nxt  = S_REQ;
                end
            end
            S_REQ: begin
                w_clk_oe_nxt = 1'b0;
                w_cnt_nxt    = '0;
                w_state_nxt  = S_DATA;
            end
            S_DATA: if (w_timeout) w_fail = 1'b1;
            else begin
                w_cnt_nxt = r_cnt + ONE;
                if (w_fall) begin
                    w_dat_oe_nxt = ~r_shift[1];
                    w_shift_nxt  = {1'b1, r_shift[10:1]};
                    w_bitcnt_nxt = r_bitcnt + 4'd1;
                    w_state_nxt  = (r_bitcnt == 4'd9) ? S_ACK : S_DATA;
                end
            end
            S_ACK: if (w_timeout) w_fail = 1'b1;
            else begin
                w_cnt_nxt = r_cnt + ONE;
                if (w_fall) begin
                    w_fail      = r_dat_s;
                    w_state_nxt = S_WAIT_IDLE;
                end
            end
            S_WAIT_IDLE: if (w_timeout) w_fail = 1'b1;
            else begin
                w_cnt_nxt = r_cnt + ONE;
                if (r_clk_s & r_dat_s) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_ERR: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_fail) begin
`ifdef PS2_TX_RETRY_EN
            if (r_retry == 2'd2) begin
                w_state_nxt  = S_ERR;
                w_clk_oe_nxt = 1'b0;
                w_dat_oe_nxt = 1'b0;
            end else begin
                w_retry_nxt  = r_retry + 2'd1;
                w_state_nxt  = S_INHIBIT;
                w_cnt_nxt    = '0;
                w_bitcnt_nxt = '0;
                w_shift_nxt  = r_frame;
                w_clk_oe_nxt = 1'b1;
                w_dat_oe_nxt = 1'b0;
            end
`else
            w_state_nxt  = S_ERR;
            w_clk_oe_nxt = 1'b0;
            w_dat_oe_nxt = 1'b0;
`endif
        end
    end

    // Synchronisers reset high so an idle bus never looks like a clock fall.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_clk_m  <= 1'b1;
            r_clk_s  <= 1'b1;
            r_clk_q  <= 1'b1;
            r_dat_m  <= 1'b1;
            r_dat_s  <= 1'b1;
            r_cnt    <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_done   <= 1'b0;
`ifdef PS2_TX_RETRY_EN
            r_frame  <= '0;
            r_retry  <= '0;
`endif
        end else begin
            r_clk_m  <= i_ps2_clk_in;
            r_clk_s  <= r_clk_m;
            r_clk_q  <= r_clk_s;
            r_dat_m  <= i_ps2_dat_in;
            r_dat_s  <= r_dat_m;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_clk_oe <= w_clk_oe_nxt;
            r_dat_oe <= w_dat_oe_nxt;
            r_done   <= w_done_nxt;
`ifdef PS2_TX_RETRY_EN
            r_frame  <= w_frame_nxt;
            r_retry  <= w_retry_nxt;
`endif
        end
    end

    assign o_tx_ready   = (r_state == S_IDLE);
    assign o_rx_inhibit = (r_state != S_IDLE);
    assign o_ps2_clk_oe = r_clk_oe;
    assign o_ps2_dat_oe = r_dat_oe;
    assign o_tx_done    = r_done;
    assign o_tx_err     = (r_state == S_ERR);
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: drives ps2_host_tx with a behavioural PS/2 device and checks frames, handshakes and errors.
module tb_ps2_host_tx;
    localparam int INH = 100;
    localparam int TO  = 2000;
`ifdef PS2_TX_RETRY_EN
    localparam int FRAMES = 3;
`else
    localparam int FRAMES = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n, tx_valid, tx_ready, clk_oe, dat_oe, rx_inhibit, tx_done, tx_err;
    logic [7:0] tx_data;
    logic       dev_clk_low, dev_dat_low, clk_pad, dat_pad;
    int         checks = 0, errors = 0, done_cnt = 0, err_cnt = 0;

    assign clk_pad = ~(clk_oe | dev_clk_low);
    assign dat_pad = ~(dat_oe | dev_dat_low);

    ps2_host_tx #(.CLK_HZ(1_000_000), .INHIBIT_US(INH), .TIMEOUT_US(TO)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(tx_data), .i_tx_valid(tx_valid),
        .o_tx_ready(tx_ready), .i_ps2_clk_in(clk_pad), .i_ps2_dat_in(dat_pad),
        .o_ps2_clk_oe(clk_oe), .o_ps2_dat_oe(dat_oe), .o_rx_inhibit(rx_inhibit),
        .o_tx_done(tx_done), .o_tx_err(tx_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (tx_done) done_cnt++;
        if (tx_err) err_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bits the device should see on pulses 1..10: data LSB first, odd parity, stop.
    function automatic logic [9:0] exp_bits(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2 == 0);
        return {1'b1, par, d};
    endfunction

    task automatic send(input logic [7:0] d);
        tx_data  = d;
        tx_valid = 1'b1;
        chk("ready_at_request", tx_ready, 1);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("clk_oe_after_accept", clk_oe, 1);
    endtask

    task automatic device_run(input bit ack, input int poke, output logic [9:0] bits,
                              output int inh_len, output logic start_bit);
        int n;
        bits = 'x;
        inh_len = 0;
        n = 0;
        while (!clk_oe && n < 1000) begin @(negedge clk); n++; end
        while (clk_oe && inh_len < 1000) begin @(negedge clk); inh_len++; end
        start_bit = dat_oe;
        repeat (10) @(negedge clk);
        for (int p = 1; p <= 11; p++) begin
            if (p == 11 && ack) begin
                dev_dat_low = 1'b1;
                repeat (5) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clk);
            if (p <= 10) bits[p-1] = dat_pad;
            if (p == 5) begin
                chk("ready_mid_frame", tx_ready, 0);
                chk("rx_inhibit_mid_frame", rx_inhibit, 1);
            end
            dev_clk_low = 1'b0;
            if (p == poke) begin
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
                repeat (19) @(negedge clk);
            end else repeat (20) @(negedge clk);
            dev_dat_low = 1'b0;
        end
    endtask

    task automatic run_ok(input logic [7:0] d, input int poke);
        logic [9:0] bits;
        int inh, d0, e0;
        logic st;
        d0 = done_cnt;
        e0 = err_cnt;
        send(d);
        device_run(1'b1, poke, bits, inh, st);
        chk("inhibit_len", inh, INH);
        chk("start_bit", st, 1);
        chk("frame_bits", bits, exp_bits(d));
        repeat (50) @(negedge clk);
        chk("done_pulses", done_cnt - d0, 1);
        chk("err_pulses", err_cnt - e0, 0);
        chk("ready_after_done", tx_ready, 1);
        chk("rx_inhibit_after_done", rx_inhibit, 0);
        chk("clk_oe_after_done", clk_oe, 0);
    endtask

    initial begin
        logic [9:0] bits;
        int inh, n, d0, e0;
        logic st;
        rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; dev_clk_low = 1'b0; dev_dat_low = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", tx_ready, 1);
        chk("rst_clk_oe", clk_oe, 0);
        chk("rst_dat_oe", dat_oe, 0);
        chk("rst_rx_inhibit", rx_inhibit, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_err", tx_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_ok(8'hED, 0);
        run_ok(8'h01, 0);
        run_ok(8'h00, 0);
        for (int i = 0; i < 3; i++) run_ok(8'($urandom_range(0, 255)), 0);

        // Device never clocks.
        e0 = err_cnt;
        send(8'hA5);
        n = 0;
        while (clk_oe && n < 1000) begin @(negedge clk); n++; end
        n = 0;
        while (!tx_err && n < 10000) begin @(negedge clk); n++; end
        chk("timeout_cycles", n, FRAMES * TO + (FRAMES - 1) * INH);
        chk("timeout_clk_oe", clk_oe, 0);
        chk("timeout_dat_oe", dat_oe, 0);
        repeat (20) @(negedge clk);
        chk("timeout_err_pulses", err_cnt - e0, 1);
        chk("timeout_ready", tx_ready, 1);

        // Device leaves data high at the ack clock.
        d0 = done_cnt;
        e0 = err_cnt;
        tx_data = 8'h3C;
        send(8'h3C);
        for (int f = 0; f < FRAMES; f++) begin
            device_run(1'b0, 0, bits, inh, st);
            chk("nack_frame_bits", bits, exp_bits(8'h3C));
        end
        repeat (50) @(negedge clk);
        chk("nack_err_pulses", err_cnt - e0, 1);
        chk("nack_done_pulses", done_cnt - d0, 0);
        chk("nack_ready", tx_ready, 1);

        // Reset after the 4th fall, with a simultaneous request.
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'hED);
        n = 0;
        while (clk_oe && n < 1000) begin @(negedge clk); n++; end
        repeat (10) @(negedge clk);
        for (int p = 0; p < 3; p++) begin
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (20) @(negedge clk);
        end
        dev_clk_low = 1'b1;
        repeat (5) @(negedge clk);
        chk("pre_reset_busy", tx_ready, 0);
        rst_n = 1'b0;
        tx_valid = 1'b1;
        tx_data = 8'h33;
        @(negedge clk);
        chk("midrst_clk_oe", clk_oe, 0);
        chk("midrst_dat_oe", dat_oe, 0);
        chk("midrst_ready", tx_ready, 1);
        chk("midrst_rx_inhibit", rx_inhibit, 0);
        chk("midrst_done", tx_done, 0);
        chk("midrst_err", tx_err, 0);
        rst_n = 1'b1;
        tx_valid = 1'b0;
        dev_clk_low = 1'b0;
        repeat (50) @(negedge clk);
        chk("midrst_no_done", done_cnt - d0, 0);
        chk("midrst_no_err", err_cnt - e0, 0);

        // Request with 0x55 during a frame of 0xED must be dropped.
        run_ok(8'hED, 4);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (clk_oe) n++;
        end
        chk("poke_no_new_frame", n, 0);
        chk("poke_ready", tx_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
